// File: rtl/fft_pkg.sv
// Shared constants and helpers for the audio FFT datapath.
// Optional feature: FFT_BFLY_SCALE_EN selects a per-stage divide-by-2 in the butterfly.
package fft_pkg;

  localparam int unsigned TW_W      = 13;
  localparam int unsigned TW_FRAC   = 12;
  localparam int unsigned FFT_N     = 128;
  localparam int unsigned TW_ADDR_W = 6;

  // Half an LSB of the twiddle fraction, for round-half-up.
  localparam int unsigned RND_CONST = 1 << (TW_FRAC - 1);

  // Output growth of a butterfly stage relative to the operand width.
`ifdef FFT_BFLY_SCALE_EN
  localparam int unsigned OW_GROW = 0;
`else
  localparam int unsigned OW_GROW = 1;
`endif

  localparam int unsigned SAT_W = 64;

  // Clamp a signed value into an ow-bit signed range; ovf flags a clamp.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input  logic signed [SAT_W-1:0] x,
    input  int unsigned             ow,
    output logic                    ovf
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    if (x > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (x < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/fft_butterfly_if.sv
// Operand/result bundle between the FFT controller, the butterfly and the stage RAM.
interface fft_butterfly_if
  import fft_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned TAG_W = 7
);

  localparam int unsigned OW = DW + OW_GROW;

  logic                   en;
  logic                   in_valid;
  logic signed [DW-1:0]   a_re;
  logic signed [DW-1:0]   a_im;
  logic signed [DW-1:0]   b_re;
  logic signed [DW-1:0]   b_im;
  logic signed [TW_W-1:0] w_re;
  logic signed [TW_W-1:0] w_im;
  logic [TAG_W-1:0]       in_tag;

  logic                   out_valid;
  logic signed [OW-1:0]   x_re;
  logic signed [OW-1:0]   x_im;
  logic signed [OW-1:0]   y_re;
  logic signed [OW-1:0]   y_im;
  logic [TAG_W-1:0]       out_tag;
  logic                   ovf;

  modport master (
    output en, in_valid, a_re, a_im, b_re, b_im, w_re, w_im, in_tag,
    input  out_valid, x_re, x_im, y_re, y_im, out_tag, ovf
  );

  modport slave (
    input  en, in_valid, a_re, a_im, b_re, b_im, w_re, w_im, in_tag,
    output out_valid, x_re, x_im, y_re, y_im, out_tag, ovf
  );

endinterface

// File: rtl/fft_cmul.sv
// Two-stage complex multiplier W*B with round-half-up back to DW+1 bits.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic signed [DW-1:0]   i_b_re,
  input  logic signed [DW-1:0]   i_b_im,
  input  logic signed [TW_W-1:0] i_w_re,
  input  logic signed [TW_W-1:0] i_w_im,
  output logic signed [DW:0]     o_wb_re,
  output logic signed [DW:0]     o_wb_im
);

  localparam int unsigned PW  = DW + TW_W;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned WBW = DW + 1;

  logic signed [PW-1:0]  r_p_rr;
  logic signed [PW-1:0]  r_p_ii;
  logic signed [PW-1:0]  r_p_ri;
  logic signed [PW-1:0]  r_p_ir;
  logic signed [SW-1:0]  w_p_re;
  logic signed [SW-1:0]  w_p_im;
  logic signed [SW-1:0]  w_sh_re;
  logic signed [SW-1:0]  w_sh_im;
  logic signed [WBW-1:0] r_wb_re;
  logic signed [WBW-1:0] r_wb_im;

  // Combine partial products and round away the twiddle fraction.
  always_comb begin
    w_p_re  = SW'(r_p_rr) - SW'(r_p_ii);
    w_p_im  = SW'(r_p_ri) + SW'(r_p_ir);
    w_sh_re = (w_p_re + $signed(SW'(RND_CONST))) >>> TW_FRAC;
    w_sh_im = (w_p_im + $signed(SW'(RND_CONST))) >>> TW_FRAC;
  end

  // Product stage followed by the rounded W*B stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_rr  <= '0;
      r_p_ii  <= '0;
      r_p_ri  <= '0;
      r_p_ir  <= '0;
      r_wb_re <= '0;
      r_wb_im <= '0;
    end else if (i_en) begin
      r_p_rr  <= PW'(i_b_re) * PW'(i_w_re);
      r_p_ii  <= PW'(i_b_im) * PW'(i_w_im);
      r_p_ri  <= PW'(i_b_re) * PW'(i_w_im);
      r_p_ir  <= PW'(i_b_im) * PW'(i_w_re);
      r_wb_re <= WBW'(w_sh_re);
      r_wb_im <= WBW'(w_sh_im);
    end
  end

  assign o_wb_re = r_wb_re;
  assign o_wb_im = r_wb_im;

endmodule

// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B, four register stages.
// Optional feature: define FFT_BFLY_SCALE_EN to halve each result (OW = DW instead of DW+1).
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned TAG_W = 7
) (
  input logic            clk,
  input logic            rst_n,
  fft_butterfly_if.slave bus
);

  localparam int unsigned OW  = DW + OW_GROW;
  localparam int unsigned WBW = DW + 1;
  localparam int unsigned SW  = DW + 2;

  // S1 operand registers
  logic                   r_s1_valid;
  logic [TAG_W-1:0]       r_s1_tag;
  logic signed [DW-1:0]   r_s1_a_re;
  logic signed [DW-1:0]   r_s1_a_im;
  logic signed [DW-1:0]   r_s1_b_re;
  logic signed [DW-1:0]   r_s1_b_im;
  logic signed [TW_W-1:0] r_s1_w_re;
  logic signed [TW_W-1:0] r_s1_w_im;

  // A / tag / valid delay line aligned with the multiplier
  logic                   r_s2_valid;
  logic                   r_s3_valid;
  logic [TAG_W-1:0]       r_s2_tag;
  logic [TAG_W-1:0]       r_s3_tag;
  logic signed [DW-1:0]   r_s2_a_re;
  logic signed [DW-1:0]   r_s2_a_im;
  logic signed [DW-1:0]   r_s3_a_re;
  logic signed [DW-1:0]   r_s3_a_im;

  logic signed [WBW-1:0]  w_wb_re;
  logic signed [WBW-1:0]  w_wb_im;

  // S4 arithmetic
  logic signed [SW-1:0]   w_s_x_re;
  logic signed [SW-1:0]   w_s_x_im;
  logic signed [SW-1:0]   w_s_y_re;
  logic signed [SW-1:0]   w_s_y_im;
  logic signed [SW-1:0]   w_q_x_re;
  logic signed [SW-1:0]   w_q_x_im;
  logic signed [SW-1:0]   w_q_y_re;
  logic signed [SW-1:0]   w_q_y_im;
  logic signed [OW-1:0]   w_x_re;
  logic signed [OW-1:0]   w_x_im;
  logic signed [OW-1:0]   w_y_re;
  logic signed [OW-1:0]   w_y_im;
  logic                   w_ovf_x_re;
  logic                   w_ovf_x_im;
  logic                   w_ovf_y_re;
  logic                   w_ovf_y_im;

  // Output registers
  logic                   r_out_valid;
  logic [TAG_W-1:0]       r_out_tag;
  logic                   r_ovf;
  logic signed [OW-1:0]   r_x_re;
  logic signed [OW-1:0]   r_x_im;
  logic signed [OW-1:0]   r_y_re;
  logic signed [OW-1:0]   r_y_im;

  fft_cmul #(
    .DW (DW)
  ) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (bus.en),
    .i_b_re  (r_s1_b_re),
    .i_b_im  (r_s1_b_im),
    .i_w_re  (r_s1_w_re),
    .i_w_im  (r_s1_w_im),
    .o_wb_re (w_wb_re),
    .o_wb_im (w_wb_im)
  );

  // Sum/difference, optional halving, then saturation into the output width.
  always_comb begin
    w_s_x_re = SW'(r_s3_a_re) + SW'(w_wb_re);
    w_s_x_im = SW'(r_s3_a_im) + SW'(w_wb_im);
    w_s_y_re = SW'(r_s3_a_re) - SW'(w_wb_re);
    w_s_y_im = SW'(r_s3_a_im) - SW'(w_wb_im);
`ifdef FFT_BFLY_SCALE_EN
    w_q_x_re = (w_s_x_re + SW'(1)) >>> 1;
    w_q_x_im = (w_s_x_im + SW'(1)) >>> 1;
    w_q_y_re = (w_s_y_re + SW'(1)) >>> 1;
    w_q_y_im = (w_s_y_im + SW'(1)) >>> 1;
`else
    w_q_x_re = w_s_x_re;
    w_q_x_im = w_s_x_im;
    w_q_y_re = w_s_y_re;
    w_q_y_im = w_s_y_im;
`endif
    w_x_re = OW'(sat_signed(64'(w_q_x_re), OW, w_ovf_x_re));
    w_x_im = OW'(sat_signed(64'(w_q_x_im), OW, w_ovf_x_im));
    w_y_re = OW'(sat_signed(64'(w_q_y_re), OW, w_ovf_y_re));
    w_y_im = OW'(sat_signed(64'(w_q_y_im), OW, w_ovf_y_im));
  end

  // S1 capture, delay line and S4 output registers; en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_tag    <= '0;
      r_s1_a_re   <= '0;
      r_s1_a_im   <= '0;
      r_s1_b_re   <= '0;
      r_s1_b_im   <= '0;
      r_s1_w_re   <= '0;
      r_s1_w_im   <= '0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_s2_tag    <= '0;
      r_s3_tag    <= '0;
      r_s2_a_re   <= '0;
      r_s2_a_im   <= '0;
      r_s3_a_re   <= '0;
      r_s3_a_im   <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_ovf       <= 1'b0;
      r_x_re      <= '0;
      r_x_im      <= '0;
      r_y_re      <= '0;
      r_y_im      <= '0;
    end else if (bus.en) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_tag    <= bus.in_tag;
      r_s1_a_re   <= bus.a_re;
      r_s1_a_im   <= bus.a_im;
      r_s1_b_re   <= bus.b_re;
      r_s1_b_im   <= bus.b_im;
      r_s1_w_re   <= bus.w_re;
      r_s1_w_im   <= bus.w_im;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_s2_tag    <= r_s1_tag;
      r_s3_tag    <= r_s2_tag;
      r_s2_a_re   <= r_s1_a_re;
      r_s2_a_im   <= r_s1_a_im;
      r_s3_a_re   <= r_s2_a_re;
      r_s3_a_im   <= r_s2_a_im;
      r_out_valid <= r_s3_valid;
      r_out_tag   <= r_s3_tag;
      r_ovf       <= r_s3_valid & (w_ovf_x_re | w_ovf_x_im | w_ovf_y_re | w_ovf_y_im);
      r_x_re      <= w_x_re;
      r_x_im      <= w_x_im;
      r_y_re      <= w_y_re;
      r_y_im      <= w_y_im;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_tag   = r_out_tag;
  assign bus.ovf       = r_ovf;
  assign bus.x_re      = r_x_re;
  assign bus.x_im      = r_x_im;
  assign bus.y_re      = r_y_re;
  assign bus.y_im      = r_y_im;

endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: randomized and directed butterflies against an arithmetic model.
module tb_fft_butterfly;

  localparam int unsigned DW    = 16;
  localparam int unsigned TAG_W = 7;
`ifdef FFT_BFLY_SCALE_EN
  localparam int unsigned OW = DW;
`else
  localparam int unsigned OW = DW + 1;
`endif

  typedef struct {
    longint xr;
    longint xi;
    longint yr;
    longint yi;
    longint ovf;
    longint tag;
    longint due;
  } exp_t;

  logic   clk;
  logic   rst_n;
  exp_t   q[$];
  longint en_cnt;
  int     n_chk;
  int     n_fail;

  fft_butterfly_if #(.DW(DW), .TAG_W(TAG_W)) bus ();

  fft_butterfly #(.DW(DW), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Butterfly from first principles: exact complex product, round half-up, sum, scale, clamp.
  function automatic exp_t model(input int ar, ai, br, bi, wr, wi, tg, input longint due);
    exp_t   e;
    longint pr, pi, wbr, wbi, hi, lo;
    longint s[4];
    pr  = longint'(br) * wr - longint'(bi) * wi;
    pi  = longint'(br) * wi + longint'(bi) * wr;
    wbr = (pr + 2048) >>> 12;
    wbi = (pi + 2048) >>> 12;
    s[0] = ar + wbr;
    s[1] = ai + wbi;
    s[2] = ar - wbr;
    s[3] = ai - wbi;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -hi - 1;
    e.ovf = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef FFT_BFLY_SCALE_EN
      s[k] = (s[k] + 1) >>> 1;
`endif
      if (s[k] > hi) begin s[k] = hi; e.ovf = 1; end
      if (s[k] < lo) begin s[k] = lo; e.ovf = 1; end
    end
    e.xr = s[0]; e.xi = s[1]; e.yr = s[2]; e.yi = s[3];
    e.tag = tg & 127;
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; accepted operands go to the scoreboard.
  task automatic issue(input bit e, input bit v, input int ar, ai, br, bi, wr, wi, tg);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.en       = e;
    bus.in_valid = v;
    bus.a_re     = 16'(ar);
    bus.a_im     = 16'(ai);
    bus.b_re     = 16'(br);
    bus.b_im     = 16'(bi);
    bus.w_re     = 13'(wr);
    bus.w_im     = 13'(wi);
    bus.in_tag   = 7'(tg);
    if (e && v) q.push_back(model(ar, ai, br, bi, wr, wi, tg, en_cnt + 4));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_d();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rnd_w();
    return int'($urandom_range(0, 8190)) - 4095;
  endfunction

  task automatic rand_issue(input bit e, input int tg);
    issue(e, 1'b1, rnd_d(), rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(), tg);
  endtask

  // Monitor: reset values, freeze under stall, and in-order scoreboard compare.
  initial begin : monitor
    exp_t e;
    logic signed [63:0] l_v, l_xr, l_xi, l_yr, l_yi, l_tag, l_ovf;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_ovf", 64'(bus.ovf), 0);
        chk("rst_out_tag", 64'(bus.out_tag), 0);
        chk("rst_x_re", 64'(bus.x_re), 0);
        chk("rst_y_im", 64'(bus.y_im), 0);
      end else if (!bus.en) begin
        chk("stall_out_valid", 64'(bus.out_valid), l_v);
        chk("stall_x_re", 64'(bus.x_re), l_xr);
        chk("stall_x_im", 64'(bus.x_im), l_xi);
        chk("stall_y_re", 64'(bus.y_re), l_yr);
        chk("stall_y_im", 64'(bus.y_im), l_yi);
        chk("stall_out_tag", 64'(bus.out_tag), l_tag);
      end else begin
        en_cnt++;
        if (bus.out_valid === 1'b1) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got tag %0d expected no output (t=%0t)", bus.out_tag, $time);
          end else begin
            e = q.pop_front();
            chk("latency", en_cnt, e.due);
            chk("out_tag", 64'(bus.out_tag), e.tag);
            chk("x_re", 64'(bus.x_re), e.xr);
            chk("x_im", 64'(bus.x_im), e.xi);
            chk("y_re", 64'(bus.y_re), e.yr);
            chk("y_im", 64'(bus.y_im), e.yi);
            chk("ovf", 64'(bus.ovf), e.ovf);
          end
        end else if (q.size() != 0 && q[0].due <= en_cnt) begin
          n_chk++;
          n_fail++;
          $display("FAIL missing_output: got out_valid 0 expected tag %0d (t=%0t)", q[0].tag, $time);
          void'(q.pop_front());
        end
      end
      l_v   = 64'(bus.out_valid);
      l_xr  = 64'(bus.x_re);
      l_xi  = 64'(bus.x_im);
      l_yr  = 64'(bus.y_re);
      l_yi  = 64'(bus.y_im);
      l_tag = 64'(bus.out_tag);
      l_ovf = 64'(bus.ovf);
    end
  end

  // Stimulus sequence.
  initial begin : driver
    n_chk  = 0;
    n_fail = 0;
    en_cnt = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    bus.w_re = '0; bus.w_im = '0; bus.in_tag = '0;
    repeat (3) @(negedge clk);

    // Directed: identity, -j, saturation, extreme negative operands.
    issue(1'b1, 1'b1, 1000, 0, 2000, 0, 4095, 0, 5);
    issue(1'b1, 1'b1, 500, 300, 100, 0, 0, -4096, 6);
    issue(1'b1, 1'b1, 32767, 0, 32767, 32767, 2895, -2897, 7);
    issue(1'b1, 1'b1, -32768, -32768, -32768, -32768, -4096, 0, 9);
`ifdef FFT_BFLY_SCALE_EN
    issue(1'b1, 1'b1, 32767, 0, 32767, 0, 4095, 0, 8);
`endif
    idle(6);

    // Back-to-back burst with a 3-cycle stall in the middle.
    for (int i = 0; i < 64; i++) begin
      if (i == 30) begin
        for (int s = 0; s < 3; s++) rand_issue(1'b0, 127);
      end
      rand_issue(1'b1, i);
    end
    idle(8);

    // Reset (with en low) while three items are in flight; none may emerge.
    for (int i = 0; i < 3; i++) rand_issue(1'b1, 100 + i);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    idle(8);

    // Random mix of bubbles and stalls.
    for (int i = 0; i < 150; i++) begin
      rand_issue(($urandom_range(0, 9) != 0), i);
      if ($urandom_range(0, 3) == 0) bus.in_valid = 1'b0;
      if (bus.in_valid == 1'b0 && bus.en == 1'b1) void'(q.pop_back());
    end

    // Drain with a bounded cycle budget.
    for (int i = 0; i < 30 && q.size() != 0; i++) idle(1);
    idle(2);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
